// File: rtl/helios_stream_fifo.sv
// -----------------------------------------------------------------------------
// helios_stream_fifo
//
// Synchronous valid/ready stream FIFO with first-word-fall-through output.
// Used between the host/test interface and the Helios decoder core to carry
// syndrome words in and root/cycle/iteration report words out. Words pass
// through unmodified and in order; the FIFO only absorbs stalls on either side.
//
// Ports
//   clk           in   1      single clock, all logic on posedge
//   reset         in   1      synchronous, active-high reset
//   input_data    in   WIDTH  write-side word
//   input_valid   in   1      write side offers input_data
//   input_ready   out  1      FIFO can accept a word this cycle
//   output_data   out  WIDTH  head-of-queue word, zero when empty
//   output_valid  out  1      output_data holds a valid word
//   output_ready  in   1      read side consumes the head word this cycle
// -----------------------------------------------------------------------------
module helios_stream_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_data,
  output logic             output_valid,
  input  logic             output_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Both handshake flags come from registered count only, so there is no
  // combinational path from output_ready to input_ready: a full FIFO refuses
  // a write even when the head is popped in the same cycle.
  assign input_ready  = (count != CNT_W'(DEPTH));
  assign output_valid = (count != '0);
  assign output_data  = output_valid ? mem[rd_ptr] : '0;

  assign push = input_valid  & input_ready;
  assign pop  = output_valid & output_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because output_data is masked by count, and leaving it unreset lets the
  // array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= input_data;
  end

endmodule

// File: tb/tb_helios_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_helios_stream_fifo
//
// Self-checking bench for helios_stream_fifo. A queue-based model tracks the
// expected contents; one compare process checks every DUT output against it
// on each falling edge, and directed sections add hand-computed literals.
// -----------------------------------------------------------------------------
module tb_helios_stream_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 128;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] input_data = '0;
  logic             input_valid = 1'b0;
  logic             input_ready;
  logic [WIDTH-1:0] output_data;
  logic             output_valid;
  logic             output_ready = 1'b0;

  int checks   = 0;
  int failures = 0;

  helios_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a queue of stored words, updated from the inputs only.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] model_q[$];
  bit               model_live = 0;
  int               model_pops = 0;

  always @(posedge clk) begin
    bit do_push, do_pop;
    if (reset) begin
      model_q.delete();
      model_live = 1;
    end else if (model_live) begin
      do_push = input_valid  && (model_q.size() < DEPTH);
      do_pop  = output_ready && (model_q.size() > 0);
      if (do_pop) begin
        void'(model_q.pop_front());
        model_pops++;
      end
      if (do_push) model_q.push_back(input_data);
    end
  end

  // Compare process: outputs are stable away from the rising edge.
  always @(negedge clk) begin
    if (model_live) begin
      logic [WIDTH-1:0] exp_data;
      exp_data = (model_q.size() > 0) ? model_q[0] : '0;
      check("model_input_ready",  input_ready,  model_q.size() != DEPTH);
      check("model_output_valid", output_valid, model_q.size() != 0);
      check("model_output_data",  output_data,  exp_data);
    end
  end

  // One clock; inputs change 1 ns after the falling edge so the compare has run.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    input_valid  = iv;
    input_data   = d;
    output_ready = ordy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0);
    cycle();
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      check("idle_input_ready",  input_ready,  1'b1);
      check("idle_output_valid", output_valid, 1'b0);
      check("idle_output_data",  output_data,  '0);
      cycle();
    end

    // Fill 0..127 with the read side stalled.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0);
      cycle();
      check("fill_head_zero", output_data, '0);
      check("fill_ready", input_ready, (i == DEPTH - 1) ? 1'b0 : 1'b1);
    end
    // 129th word offered for two cycles is refused.
    drive(1'b1, 32'd999, 1'b0);
    cycle();
    cycle();
    check("full_ready_low", input_ready, 1'b0);
    check("full_valid",     output_valid, 1'b1);
    check("full_head",      output_data, '0);
    check("full_size",      model_q.size(), DEPTH);

    // Drain in order, one per cycle; no new writes offered.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      check("drain_data", output_data, WIDTH'(i));
      cycle();
      check("drain_ready_after_pop", input_ready, 1'b1);
    end
    check("drain_valid_low", output_valid, 1'b0);
    check("drain_data_zero", output_data, '0);
    drive(1'b0, '0, 1'b0);
    cycle();

    // Continuous stream: 300 words with both sides always willing.
    do_reset();
    model_pops = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 32'h1000 + WIDTH'(i), 1'b1);
      cycle();
      check("stream_head", output_data, 32'h1000 + WIDTH'(i));
      check("stream_ready", input_ready, 1'b1);
    end
    check("stream_pops", model_pops, 299);
    drive(1'b0, '0, 1'b1);
    cycle();
    check("stream_empty", output_valid, 1'b0);

    // All-ones word into an empty FIFO: visible only after the edge.
    drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    check("ones_before_edge", output_valid, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0);
    check("ones_valid", output_valid, 1'b1);
    check("ones_data",  output_data, 32'hFFFF_FFFF);
    drive(1'b0, '0, 1'b1);
    cycle();
    check("ones_popped", output_valid, 1'b0);

    // Five words then a reset, with a push offered during the reset cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h50 + WIDTH'(i), 1'b0);
      cycle();
    end
    check("pre_reset_head", output_data, 32'h50);
    drive(1'b1, 32'hDEAD, 1'b1);
    do_reset();
    drive(1'b0, '0, 1'b0);
    check("post_reset_valid", output_valid, 1'b0);
    check("post_reset_ready", input_ready, 1'b1);
    drive(1'b1, 32'hABCD, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b1);
    check("post_reset_next", output_data, 32'hABCD);
    cycle();
    check("post_reset_drained", output_valid, 1'b0);

    // Randomized phases with varying fill/drain bias and rare resets.
    for (int phase = 0; phase < 6; phase++) begin
      int pv, pr;
      pv = (phase % 3 == 0) ? 90 : (phase % 3 == 1) ? 20 : 50;
      pr = (phase % 3 == 0) ? 20 : (phase % 3 == 1) ? 90 : 50;
      for (int i = 0; i < 400; i++) begin
        reset = ($urandom_range(0, 299) == 0);
        drive($urandom_range(0, 99) < pv, $urandom, $urandom_range(0, 99) < pr);
        cycle();
      end
    end
    reset = 1'b0;
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) cycle();
    check("final_empty", output_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
